draw_msg_box: RTL
=================

// Module: draw_msg_box
// PURPOSE
//  Parametrised text-banner overlay in the VGA pipeline (hcount/vcount/sync/blnk/rgb in -> same out).
//  Draws a COLS x ROWS character box of scaled 8x16 glyphs at (X_POS,Y_POS), fetched via char_yx/char_line.
//  Frame-synchronous show/hide FSM with optional auto-hide timeout and optional blink.
//  One instance per message (win, lose, pause); replaces the fixed single-message drawers.
// PARAMETERS
//  X_POS        288      left edge of box, pixels
//  Y_POS        208      top edge of box, pixels
//  COLS         7        characters per row, 1..16
//  ROWS         1        character rows, 1..16
//  SCALE_LOG2   2        glyph pixel = 2^S x 2^S screen pixels; cell = (8<<S) x (16<<S)
//  FONT_LAT     1        cycles from char_yx/char_line change to matching char_pixels, 1..4
//  HOLD_FRAMES  0        frames before auto-hide; 0 = stay until hide_req
//  BLINK_FRAMES 30       frames per blink half-period (MSG_BOX_BLINK_EN only), >=1
//  COLOR_BG     12'hbdf  box background
//  COLOR_FG     12'hb1f  glyph colour
// PORTS
//  pclk         in   1   pixel clock
//  rst          in   1   synchronous reset, active-low
//  hcount_in    in   11  / hsync_in in 1 / hblnk_in in 1  horizontal timing
//  vcount_in    in   11  / vsync_in in 1 / vblnk_in in 1  vertical timing
//  rgb_in       in   12  upstream colour
//  show_req     in   1   pulse: request box visible
//  hide_req     in   1   pulse: request box hidden
//  char_pixels  in   8   glyph row; bit 7 = leftmost pixel
//  hcount_out.. out  11/1/1/11/1/1  timing delayed by L = FONT_LAT+2
//  rgb_out      out  12  composited colour
//  char_yx      out  8   {row[3:0], col[3:0]} to char ROM
//  char_line    out  4   glyph row 0..15 to font ROM
//  visible      out  1   FSM not in HIDDEN
//  timeout      out  1   1-cycle pulse on auto-hide
// BEHAVIOUR
//  Reset (rst=0 at pclk edge): every output 0, FSM=HIDDEN, counters/pending flags 0, delay lines 0.
//  Addressing (relative dx=h-X_POS, dy=v-Y_POS, 11-bit unsigned): col=dx>>(3+S), row=dy>>(4+S),
//   char_line=(dy>>S)[3:0]; char_yx/char_line registered 1 cycle after inputs; don't-care outside box.
//  Pixel: gx=(dx>>S)[2:0] carried with timing; at L, lit = char_pixels[7-gx].
//  Box hit: X_POS<=h<X_POS+COLS*(8<<S) and Y_POS<=v<Y_POS+ROWS*(16<<S), evaluated on input, delayed to L.
//  rgb_out at L: 0 if hblnk|vblnk; else if draw_on&hit: lit?COLOR_FG:COLOR_BG; else rgb_in delayed L.
//  Total latency L cycles, identical for all timing outputs and rgb_out.
//  Frame tick: rising edge of vblnk_in (registered prev). Requests latch into pending flags any cycle;
//   applied only on frame tick, so the box never changes mid-frame. Pending flags clear on tick.
//  FSM: HIDDEN -show-> SHOWN_ON (frame_cnt=0, blink_cnt=0).
//   SHOWN_ON/SHOWN_OFF -hide-> HIDDEN. show while shown: restart frame_cnt, go SHOWN_ON.
//   Same tick with show and hide pending: hide wins. Same cycle req + tick: req applies this tick.
//   HOLD_FRAMES>0: frame_cnt increments per tick while shown; at frame_cnt==HOLD_FRAMES-1 and tick
//   -> HIDDEN, timeout=1 that cycle. frame_cnt width clog2(HOLD_FRAMES+1), saturating otherwise.
//  draw_on = (state==SHOWN_ON); visible = (state!=HIDDEN); state updates only on tick.
//  Reset mid-frame: outputs 0 immediately, FSM HIDDEN; pipeline refills after L cycles.
// CONFIGURATION
//  MSG_BOX_BLINK_EN defined: blink_cnt counts ticks while shown; every BLINK_FRAMES ticks toggle
//   SHOWN_ON<->SHOWN_OFF (blink_cnt resets); SHOWN_OFF passes rgb_in through, visible stays 1.
//  Undefined: SHOWN_OFF and blink_cnt not built, BLINK_FRAMES ignored, shown box is steady.
// TESTING
//  1 rst=0 3 cycles, rgb_in=12'h123 -> all outputs 0; rst=1, no show -> rgb_out=12'h123 after L cycles.
//  2 defaults, show_req mid-frame -> box absent until next vblnk rise; next frame h=288,v=208 gives
//    char_yx=8'h00,char_line=0; h=320 gives char_yx=8'h01; lit bit -> 12'hb1f, else 12'hbdf, at L.
//  3 show_req and hide_req same cycle from HIDDEN -> stays HIDDEN, visible=0 after tick.
//  4 HOLD_FRAMES=3, show -> visible for exactly 3 frames, timeout pulse 1 cycle at 3rd following tick.
//  5 MSG_BOX_BLINK_EN, BLINK_FRAMES=2 -> box drawn 2 frames, pass-through 2 frames, repeat; visible=1.
//  6 rst=0 while shown mid-line -> next cycle outputs 0, visible=0; box absent after release.

Source files
------------

// File: rtl/draw_msg_box.sv
// Text-banner overlay for the VGA pipeline: COLS x ROWS scaled 8x16 glyphs, shown and hidden on frame ticks.
// Optional blink is built when MSG_BOX_BLINK_EN is defined.
module draw_msg_box #(
  parameter int          X_POS        = 288,
  parameter int          Y_POS        = 208,
  parameter int          COLS         = 7,
  parameter int          ROWS         = 1,
  parameter int          SCALE_LOG2   = 2,
  parameter int          FONT_LAT     = 1,
  parameter int          HOLD_FRAMES  = 0,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] COLOR_BG     = 12'hbdf,
  parameter logic [11:0] COLOR_FG     = 12'hb1f
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        show_req,
  input  logic        hide_req,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [7:0]  char_yx,
  output logic [3:0]  char_line,
  output logic        visible,
  output logic        timeout
);
  localparam int D     = FONT_LAT + 1;
  localparam int BOX_W = COLS * (8 << SCALE_LOG2);
  localparam int BOX_H = ROWS * (16 << SCALE_LOG2);
  localparam int FW    = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  typedef struct packed {
    logic [10:0] hc;
    logic        hs;
    logic        hb;
    logic [10:0] vc;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
    logic [2:0]  gx;
    logic        hit;
  } pix_t;

`ifdef MSG_BOX_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;
  typedef enum logic [1:0] {HIDDEN, SHOWN_ON, SHOWN_OFF} state_t;
  logic [BW-1:0] blink_cnt;
`else
  typedef enum logic [1:0] {HIDDEN, SHOWN_ON} state_t;
`endif

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic          vblnk_prev, show_pend, hide_pend;
  logic          tick, show_any, hide_any, draw_on, lit;
  logic [10:0]   dx, dy;
  pix_t          cur, last;
  pix_t          pipe [1:D];

  assign dx = hcount_in - 11'(X_POS);
  assign dy = vcount_in - 11'(Y_POS);

  always_comb begin
    cur.hc  = hcount_in;
    cur.hs  = hsync_in;
    cur.hb  = hblnk_in;
    cur.vc  = vcount_in;
    cur.vs  = vsync_in;
    cur.vb  = vblnk_in;
    cur.rgb = rgb_in;
    cur.gx  = 3'(dx >> SCALE_LOG2);
    cur.hit = ({1'b0, hcount_in} >= 12'(X_POS)) && ({1'b0, hcount_in} < 12'(X_POS + BOX_W)) &&
              ({1'b0, vcount_in} >= 12'(Y_POS)) && ({1'b0, vcount_in} < 12'(Y_POS + BOX_H));
  end

  // The last delay stage lines up with char_pixels returned for the same pixel.
  assign last    = pipe[D];
  assign lit     = char_pixels[3'd7 - last.gx];
  assign draw_on = (state == SHOWN_ON);

  always_ff @(posedge pclk) begin
    if (!rst) begin
      for (int i = 1; i <= D; i++) pipe[i] <= '0;
      char_yx <= '0; char_line <= '0;
      hcount_out <= '0; hsync_out <= 1'b0; hblnk_out <= 1'b0;
      vcount_out <= '0; vsync_out <= 1'b0; vblnk_out <= 1'b0;
      rgb_out <= '0;
    end else begin
      pipe[1] <= cur;
      for (int i = 2; i <= D; i++) pipe[i] <= pipe[i-1];
      char_yx   <= {4'(dy >> (4 + SCALE_LOG2)), 4'(dx >> (3 + SCALE_LOG2))};
      char_line <= 4'(dy >> SCALE_LOG2);
      hcount_out <= last.hc; hsync_out <= last.hs; hblnk_out <= last.hb;
      vcount_out <= last.vc; vsync_out <= last.vs; vblnk_out <= last.vb;
      if (last.hb || last.vb)      rgb_out <= '0;
      else if (draw_on && last.hit) rgb_out <= lit ? COLOR_FG : COLOR_BG;
      else                          rgb_out <= last.rgb;
    end
  end

  assign tick     = vblnk_in & ~vblnk_prev;
  assign show_any = show_pend | show_req;
  assign hide_any = hide_pend | hide_req;

  // State only moves on the frame tick so the box never tears mid-frame.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state <= HIDDEN; visible <= 1'b0; timeout <= 1'b0;
      vblnk_prev <= 1'b0; show_pend <= 1'b0; hide_pend <= 1'b0;
      frame_cnt <= '0;
`ifdef MSG_BOX_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      vblnk_prev <= vblnk_in;
      timeout    <= 1'b0;
      if (tick) begin
        show_pend <= 1'b0;
        hide_pend <= 1'b0;
        if (hide_any) begin
          state <= HIDDEN; visible <= 1'b0;
        end else if (show_any) begin
          state <= SHOWN_ON; visible <= 1'b1; frame_cnt <= '0;
`ifdef MSG_BOX_BLINK_EN
          blink_cnt <= '0;
`endif
        end else if (state != HIDDEN) begin
          if (HOLD_FRAMES > 0 && frame_cnt == FW'(HOLD_FRAMES - 1)) begin
            state <= HIDDEN; visible <= 1'b0; timeout <= 1'b1;
          end else begin
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
`ifdef MSG_BOX_BLINK_EN
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
              blink_cnt <= '0;
              state <= (state == SHOWN_ON) ? SHOWN_OFF : SHOWN_ON;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
`endif
          end
        end
      end else begin
        show_pend <= show_pend | show_req;
        hide_pend <= hide_pend | hide_req;
      end
    end
  end
endmodule
